// File: rtl/piso_serializer.sv
// piso_serializer
//   Parallel-in serial-out transmitter. Words arrive on a valid/ready
//   handshake into a one-word holding buffer. From there they are moved into a
//   shift register and sent one bit per clock. frame_start marks the first bit
//   of a word and frame_end marks the last. The holding buffer refills while a
//   word is shifting, so consecutive words leave with no idle cycle between them.
//
// Parameters
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 goes out first, 0: bit 0 goes out first
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   in           parallel word to transmit
//   in_valid     in holds a word
//   in_ready     holding buffer empty, a word can be accepted (from state)
//   ser_out      serial data bit (registered)
//   ser_valid    ser_out carries a bit (registered)
//   frame_start  first bit of a word (registered)
//   frame_end    last bit of a word (registered)
//   busy         holding buffer full or a word is shifting (from state)
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] hold, hold_n;
  logic             hold_full, hold_full_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             ser_out_n, frame_start_n, frame_end_n;
  logic             transfer, accept;
  logic [CW-1:0]    cnt_inc;
  logic [WIDTH-1:0] shifted;

  // The bit that leads a word on the wire, for the configured bit order.
  function automatic logic lead_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) begin
      return w[WIDTH-1];
    end else begin
      return w[0];
    end
  endfunction

  assign in_ready  = ~hold_full;
  assign ser_valid = (state == SHIFT);
  assign busy      = hold_full | (state == SHIFT);

  // Handshake, transfer and shift decisions, plus next values of all state.
  always_comb begin
    state_n       = state;
    hold_n        = hold;
    hold_full_n   = hold_full;
    shreg_n       = shreg;
    cnt_n         = cnt;
    ser_out_n     = ser_out;
    frame_start_n = frame_start;
    frame_end_n   = frame_end;

    // A held word moves out when the line is idle or the current word is on its last bit.
    transfer = hold_full && ((state == IDLE) || frame_end);
    accept   = in_valid && !hold_full;
    cnt_inc  = cnt + CW'(1);

    // The shift register is moved so the next bit to send sits in the lead position.
    if (MSB_FIRST) begin
      shifted = {shreg[WIDTH-2:0], 1'b0};
    end else begin
      shifted = {1'b0, shreg[WIDTH-1:1]};
    end

    // Holding buffer. Accept and transfer never happen together because accept needs hold empty.
    if (transfer) begin
      hold_full_n = 1'b0;
    end else if (accept) begin
      hold_n      = in;
      hold_full_n = 1'b1;
    end else begin
      hold_full_n = hold_full;
    end

    case (state)
      IDLE: begin
        if (transfer) begin
          state_n       = SHIFT;
          shreg_n       = hold;
          ser_out_n     = lead_bit(hold);
          cnt_n         = '0;
          frame_start_n = 1'b1;
          frame_end_n   = 1'b0;
        end else begin
          state_n = IDLE;
        end
      end
      SHIFT: begin
        if (transfer) begin
          // Back-to-back frame: the next word follows the last bit directly.
          state_n       = SHIFT;
          shreg_n       = hold;
          ser_out_n     = lead_bit(hold);
          cnt_n         = '0;
          frame_start_n = 1'b1;
          frame_end_n   = 1'b0;
        end else if (frame_end) begin
          state_n       = IDLE;
          shreg_n       = '0;
          ser_out_n     = 1'b0;
          cnt_n         = '0;
          frame_start_n = 1'b0;
          frame_end_n   = 1'b0;
        end else begin
          state_n       = SHIFT;
          shreg_n       = shifted;
          ser_out_n     = lead_bit(shifted);
          cnt_n         = cnt_inc;
          frame_start_n = 1'b0;
          frame_end_n   = (cnt_inc == LAST_IDX);
        end
      end
      default: begin
        state_n       = IDLE;
        shreg_n       = '0;
        ser_out_n     = 1'b0;
        cnt_n         = '0;
        frame_start_n = 1'b0;
        frame_end_n   = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset drops everything, which discards partial and held words.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      hold        <= '0;
      hold_full   <= 1'b0;
      shreg       <= '0;
      cnt         <= '0;
      ser_out     <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
    end else begin
      state       <= state_n;
      hold        <= hold_n;
      hold_full   <= hold_full_n;
      shreg       <= shreg_n;
      cnt         <= cnt_n;
      ser_out     <= ser_out_n;
      frame_start <= frame_start_n;
      frame_end   <= frame_end_n;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Testbench for piso_serializer. It drives two instances from the same
// stimulus: one sends MSB first and the other sends LSB first. A word-level
// model in the bench tracks the holding buffer and the bit position inside the
// current frame. Both instances are compared against this model on every
// falling edge. Some directed sequences also check the serial streams against
// hand-written bit patterns.
module tb_piso_serializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] in_word = '0;
  logic         in_valid = 1'b0;

  logic rdy_a, so_a, sv_a, fs_a, fe_a, busy_a;
  logic rdy_b, so_b, sv_b, fs_b, fe_b, busy_b;

  int n_checks = 0;
  int n_fail   = 0;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .reset(reset), .in(in_word), .in_valid(in_valid),
    .in_ready(rdy_a), .ser_out(so_a), .ser_valid(sv_a),
    .frame_start(fs_a), .frame_end(fe_a), .busy(busy_a)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .reset(reset), .in(in_word), .in_valid(in_valid),
    .in_ready(rdy_b), .ser_out(so_b), .ser_valid(sv_b),
    .frame_start(fs_b), .frame_end(fe_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  // Word-level reference: a held word, an active word and a bit index.
  logic         m_hold_full = 1'b0;
  logic [W-1:0] m_hold = '0;
  logic         m_active = 1'b0;
  logic [W-1:0] m_word = '0;
  int           m_idx = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at time %0t", name, act, exp, $time);
    end
  endtask

  // Reference model update. A transfer starts when a word is held and the line is free or on its last bit.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hold_full <= 1'b0;
      m_hold      <= '0;
      m_active    <= 1'b0;
      m_word      <= '0;
      m_idx       <= 0;
    end else begin
      if (m_hold_full && (!m_active || m_idx == W - 1)) begin
        m_active    <= 1'b1;
        m_word      <= m_hold;
        m_idx       <= 0;
        m_hold_full <= 1'b0;
      end else if (m_active) begin
        if (m_idx == W - 1) begin
          m_active <= 1'b0;
          m_idx    <= 0;
        end else begin
          m_idx <= m_idx + 1;
        end
      end
      if (in_valid && !m_hold_full) begin
        m_hold_full <= 1'b1;
        m_hold      <= in_word;
      end
    end
  end

  // Per-cycle comparison of both instances against the reference.
  always @(negedge clk) begin
    check("cycle_msb",
          {10'd0, sv_a, fs_a, fe_a, so_a, rdy_a, busy_a},
          {10'd0, m_active, m_active && (m_idx == 0), m_active && (m_idx == W - 1),
           m_active ? m_word[W-1-m_idx] : 1'b0, !m_hold_full, m_hold_full || m_active});
    check("cycle_lsb",
          {10'd0, sv_b, fs_b, fe_b, so_b, rdy_b, busy_b},
          {10'd0, m_active, m_active && (m_idx == 0), m_active && (m_idx == W - 1),
           m_active ? m_word[m_idx] : 1'b0, !m_hold_full, m_hold_full || m_active});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word and hold in_valid until it is accepted. in_valid is left high.
  task automatic push(input logic [W-1:0] w);
    logic r;
    bit   done;
    done     = 1'b0;
    in_word  = w;
    in_valid = 1'b1;
    for (int g = 0; g < 40 && !done; g++) begin
      @(negedge clk);
      r = rdy_a;
      tick();
      if (r) done = 1'b1;
    end
    if (!done) check("push_timeout", {15'd0, rdy_a}, 16'd1);
  endtask

  // Wait for a stream to start, then compare n bits against literal patterns (first bit is bit n-1).
  task automatic capture(input logic [15:0] bits_a, input logic [15:0] bits_b, input int n,
                         input string tag);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!sv_a && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!sv_a) begin
      check({tag, "_start_timeout"}, {15'd0, sv_a}, 16'd1);
    end else begin
      for (int i = 0; i < n; i++) begin
        if (i > 0) @(negedge clk);
        check({tag, "_bit"},
              {11'd0, sv_a, fs_a, fe_a, so_a, so_b},
              {11'd0, 1'b1, (i % W) == 0, (i % W) == W - 1, bits_a[n-1-i], bits_b[n-1-i]});
      end
      @(negedge clk);
      check({tag, "_idle_after"}, {12'd0, sv_a, sv_b, busy_a, busy_b}, 16'd0);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_state", {10'd0, sv_a, so_a, fs_a, fe_a, rdy_a, busy_a}, 16'b10);
    tick();
    reset = 1'b1;
    tick();

    // Single word 1101
    fork
      begin push(4'b1101); in_valid = 1'b0; end
      capture(16'b1101, 16'b1011, 4, "single");
    join

    // Back-to-back 1111, 0001
    tick();
    fork
      begin push(4'b1111); push(4'b0001); in_valid = 1'b0; end
      capture(16'b1111_0001, 16'b1111_1000, 8, "b2b");
    join

    // Backpressure with three words
    tick();
    fork
      begin push(4'b1111); push(4'b1101); push(4'b1100); in_valid = 1'b0; end
      capture(16'b1111_1101_1100, 16'b1111_1011_0011, 12, "bp");
    join

    // Single 1100 (LSB-first stream reads 0,0,1,1)
    tick();
    fork
      begin push(4'b1100); in_valid = 1'b0; end
      capture(16'b1100, 16'b0011, 4, "order");
    join

    // Reset mid-frame with a word held
    tick();
    push(4'b1101);
    push(4'b0110);
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("reset_mid_msb", {10'd0, sv_a, so_a, fs_a, fe_a, rdy_a, busy_a}, 16'b10);
    check("reset_mid_lsb", {10'd0, sv_b, so_b, fs_b, fe_b, rdy_b, busy_b}, 16'b10);
    tick();
    tick();
    reset = 1'b1;
    tick();
    fork
      begin push(4'b0001); in_valid = 1'b0; end
      capture(16'b0001, 16'b1000, 4, "after_reset");
    join

    // Word offered while hold is full is ignored
    tick();
    fork
      begin
        push(4'b1010);
        push(4'b0011);
        in_word  = 4'b1111;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
      end
      capture(16'b1010_0011, 16'b0101_1100, 8, "ignored");
    join

    // Random traffic with occasional resets, checked by the per-cycle model
    for (int c = 0; c < 400; c++) begin
      in_word  = W'($urandom_range(0, 15));
      in_valid = ($urandom_range(0, 3) != 0);
      reset    = ($urandom_range(0, 79) != 0);
      tick();
    end
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (12) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
